// File: rtl/tm1638_responder.sv
// Device-side TM1638 serial responder: decodes STB/CLK/DIO frames from the
// board controller, holds the 16-byte display RAM and returns key-scan bytes.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sio_clk,
    input  logic         sio_stb,
    input  logic         sio_dio_in,
    output logic         sio_dio_out,
    output logic         sio_dio_oe,
    input  logic [31:0]  key_scan,
    output logic [127:0] disp_ram,
    output logic         disp_on,
    output logic [2:0]   disp_bright,
    output logic         wr_valid,
    output logic [3:0]   wr_addr,
    output logic [7:0]   wr_data,
    output logic         frame_err
);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] stb_sync_reg;
    logic [SYNC_STAGES-1:0] dio_sync_reg;
    logic                   clk_d_reg;
    logic                   stb_d_reg;
    logic                   clk_rise_reg;
    logic                   clk_fall_reg;
    logic                   stb_rise_reg;
    logic                   stb_fall_reg;

    logic                   clk_s;
    logic                   stb_s;
    logic                   dio_s;

    state_t                 state_reg;
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt_reg;
    logic [3:0]             addr_reg;
    logic                   fixed_mode_reg;
    logic [31:0]            snap_reg;
    logic [2:0]             rd_byte_reg;
    logic [2:0]             rd_bit_reg;
    logic [7:0]             ram [16];

    logic [7:0]             rx_byte;
    logic                   bit_taken;
    logic                   byte_done;
    logic [2:0]             bits_after;
    logic [7:0]             rd_byte_val;

    assign clk_s = clk_sync_reg[SYNC_STAGES-1];
    assign stb_s = stb_sync_reg[SYNC_STAGES-1];
    assign dio_s = dio_sync_reg[SYNC_STAGES-1];

    // Synchronizers idle at the bus idle levels so reset release creates no edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_reg <= '1;
            stb_sync_reg <= '1;
            dio_sync_reg <= '0;
            clk_d_reg    <= 1'b1;
            stb_d_reg    <= 1'b1;
            clk_rise_reg <= 1'b0;
            clk_fall_reg <= 1'b0;
            stb_rise_reg <= 1'b0;
            stb_fall_reg <= 1'b0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], sio_clk};
            stb_sync_reg <= {stb_sync_reg[SYNC_STAGES-2:0], sio_stb};
            dio_sync_reg <= {dio_sync_reg[SYNC_STAGES-2:0], sio_dio_in};
            clk_d_reg    <= clk_s;
            stb_d_reg    <= stb_s;
            clk_rise_reg <= clk_s & ~clk_d_reg;
            clk_fall_reg <= ~clk_s & clk_d_reg;
            stb_rise_reg <= stb_s & ~stb_d_reg;
            stb_fall_reg <= ~stb_s & stb_d_reg;
        end
    end

    always_comb begin
        rx_byte     = {dio_s, shift_reg[7:1]};
        bit_taken   = clk_rise_reg && (state_reg != IDLE);
        byte_done   = bit_taken && (bit_cnt_reg == 3'd7);
        bits_after  = bit_taken ? bit_cnt_reg + 3'd1 : bit_cnt_reg;
        rd_byte_val = 8'h00;
        if (rd_byte_reg < 3'd4)
            rd_byte_val = snap_reg[{rd_byte_reg[1:0], 3'b000} +: 8];
    end

    // Later assignments in this block win, so a STB rise in the same cycle as
    // the last bit commits the byte first and then closes the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            addr_reg       <= '0;
            fixed_mode_reg <= 1'b0;
            snap_reg       <= '0;
            rd_byte_reg    <= '0;
            rd_bit_reg     <= '0;
            sio_dio_out    <= 1'b0;
            sio_dio_oe     <= 1'b0;
            disp_on        <= 1'b0;
            disp_bright    <= '0;
            wr_valid       <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            frame_err      <= 1'b0;
            for (int i = 0; i < 16; i++)
                ram[i] <= '0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (bit_taken) begin
                shift_reg   <= rx_byte;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end

            if (byte_done) begin
                case (state_reg)
                    CMD: begin
                        case (rx_byte[7:6])
                            2'b01: begin
                                fixed_mode_reg <= rx_byte[2];
                                if (rx_byte[1]) begin
                                    snap_reg    <= key_scan;
                                    rd_byte_reg <= '0;
                                    rd_bit_reg  <= '0;
                                    state_reg   <= RDATA;
                                end else begin
                                    state_reg <= IGNORE;
                                end
                            end
                            2'b11: begin
                                addr_reg  <= rx_byte[3:0];
                                state_reg <= WDATA;
                            end
                            2'b10: begin
                                disp_on     <= rx_byte[3];
                                disp_bright <= rx_byte[2:0];
                                state_reg   <= IGNORE;
                            end
                            default: state_reg <= IGNORE;
                        endcase
                    end
                    WDATA: begin
                        ram[addr_reg] <= rx_byte;
                        wr_valid      <= 1'b1;
                        wr_addr       <= addr_reg;
                        wr_data       <= rx_byte;
                        if (!fixed_mode_reg)
                            addr_reg <= addr_reg + 4'd1;
                    end
                    default: ;
                endcase
            end

            if (clk_fall_reg && state_reg == RDATA) begin
                sio_dio_out <= rd_byte_val[rd_bit_reg];
                sio_dio_oe  <= 1'b1;
                rd_bit_reg  <= rd_bit_reg + 3'd1;
                if (rd_bit_reg == 3'd7 && rd_byte_reg != 3'd4)
                    rd_byte_reg <= rd_byte_reg + 3'd1;
            end

            if (stb_rise_reg) begin
                state_reg   <= IDLE;
                sio_dio_oe  <= 1'b0;
                bit_cnt_reg <= '0;
                if (state_reg != IDLE && bits_after != 3'd0)
                    frame_err <= 1'b1;
            end else if (stb_fall_reg && state_reg == IDLE) begin
                state_reg   <= CMD;
                bit_cnt_reg <= '0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_disp
            assign disp_ram[8*gi +: 8] = ram[gi];
        end
    endgenerate

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: bit-banged frames, write/read scoreboards.
module tb_tm1638_responder;

    logic         clk;
    logic         rst;
    logic         sio_clk;
    logic         sio_stb;
    logic         sio_dio_in;
    logic         sio_dio_out;
    logic         sio_dio_oe;
    logic [31:0]  key_scan;
    logic [127:0] disp_ram;
    logic         disp_on;
    logic [2:0]   disp_bright;
    logic         wr_valid;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         frame_err;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int ferr_count = 0;

    logic [11:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  mram [16];
    logic [3:0]  waddr;
    logic        fixed_mode;
    logic [11:0] exp_wr;

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sio_clk(sio_clk), .sio_stb(sio_stb),
        .sio_dio_in(sio_dio_in), .sio_dio_out(sio_dio_out), .sio_dio_oe(sio_dio_oe),
        .key_scan(key_scan), .disp_ram(disp_ram), .disp_on(disp_on),
        .disp_bright(disp_bright), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_ram();
        logic [127:0] r;
        for (int a = 0; a < 16; a++) r[8*a +: 8] = mram[a];
        return r;
    endfunction

    // Write scoreboard: every wr_valid pulse must match the oldest pushed write.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_valid) begin
                wr_count++;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", {wr_addr, wr_data}, 12'hfff);
                end else begin
                    exp_wr = wr_q.pop_front();
                    check("wr_addr_data", {wr_addr, wr_data}, exp_wr);
                    $display("write addr=%0d data=%02h", wr_addr, wr_data);
                end
            end
            if (frame_err) ferr_count++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sio_clk = 1'b0;
            wait_cyc(4);
            sio_dio_in = b[i];
            wait_cyc(4);
            sio_clk = 1'b1;
            wait_cyc(8);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic stb_start();
        sio_stb = 1'b0;
        wait_cyc(8);
    endtask

    task automatic stb_end();
        wait_cyc(8);
        sio_stb = 1'b1;
        sio_dio_in = 1'b1;
        wait_cyc(10);
    endtask

    task automatic cmd_frame(input logic [7:0] c);
        stb_start();
        send_byte(c);
        stb_end();
        if (c[7:6] == 2'b01) fixed_mode = c[2];
        $display("frame cmd=%02h", c);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr_q.push_back({waddr, d});
        mram[waddr] = d;
        if (!fixed_mode) waddr = waddr + 4'd1;
        send_byte(d);
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sio_clk = 1'b0;
            wait_cyc(8);
            b[i] = sio_dio_out;
            sio_clk = 1'b1;
            wait_cyc(8);
        end
    endtask

    logic [7:0] got;
    logic [7:0] exp_rd;
    int         wr_before;

    initial begin
        rst = 1'b0; sio_clk = 1'b1; sio_stb = 1'b1; sio_dio_in = 1'b1;
        key_scan = '0; waddr = '0; fixed_mode = 1'b0;
        for (int a = 0; a < 16; a++) mram[a] = 8'h00;
        wait_cyc(5);
        check("reset_ram", disp_ram, 128'h0);
        check("reset_disp", {disp_on, disp_bright}, 4'h0);
        check("reset_dio", {sio_dio_oe, sio_dio_out}, 2'b00);
        check("reset_pulses", {wr_valid, frame_err, wr_addr, wr_data}, 14'h0);
        rst = 1'b1;
        wait_cyc(10);

        // Auto-increment over the whole RAM
        cmd_frame(8'h40);
        stb_start(); send_byte(8'hC0); waddr = 4'h0;
        for (int a = 0; a < 16; a++) wr_byte(a[7:0]);
        stb_end();
        check("auto_ram", disp_ram, model_ram());
        check("auto_count", wr_count, 16);
        check("auto_queue_empty", wr_q.size(), 0);

        // Fixed address, then auto with wrap past 15
        cmd_frame(8'h44);
        stb_start(); send_byte(8'hC3); waddr = 4'h3;
        wr_byte(8'hAA); wr_byte(8'h55);
        stb_end();
        check("fixed_ram3", disp_ram[8*3 +: 8], 8'h55);
        check("fixed_ram2_4", {disp_ram[8*2 +: 8], disp_ram[8*4 +: 8]}, 16'h0204);
        check("fixed_count", wr_count, 18);
        cmd_frame(8'h40);
        stb_start(); send_byte(8'hCE); waddr = 4'hE;
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        stb_end();
        check("wrap_ram", disp_ram, model_ram());
        check("wrap_ram0", disp_ram[7:0], 8'h33);
        check("wrap_queue_empty", wr_q.size(), 0);

        // Key read with mid-frame key_scan change
        key_scan = 32'h80402010;
        rd_q.push_back(8'h10); rd_q.push_back(8'h20); rd_q.push_back(8'h40);
        rd_q.push_back(8'h80); rd_q.push_back(8'h00);
        wr_before = wr_count;
        stb_start(); send_byte(8'h42); fixed_mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            read_byte(got);
            exp_rd = rd_q.pop_front();
            check("key_byte", got, exp_rd);
            $display("read byte %0d data=%02h", k, got);
            if (k == 1) key_scan = 32'hFFFFFFFF;
        end
        check("read_oe_active", sio_dio_oe, 1'b1);
        wait_cyc(8);
        sio_stb = 1'b1;
        wait_cyc(4);
        check("read_oe_release", sio_dio_oe, 1'b0);
        wait_cyc(10);
        check("read_no_write", wr_count, wr_before);

        // Display control
        cmd_frame(8'h8F);
        check("disp_on_7", {disp_on, disp_bright}, 4'hF);
        cmd_frame(8'h80);
        check("disp_off_0", {disp_on, disp_bright}, 4'h0);
        check("disp_no_write", wr_count, wr_before);

        // Partial byte after an address command
        stb_start(); send_byte(8'hC5); send_bits(8'hFF, 5); stb_end();
        check("partial_ferr", ferr_count, 1);
        check("partial_no_write", wr_count, wr_before);
        check("partial_ram", disp_ram, model_ram());
        stb_start(); send_byte(8'hC5); waddr = 4'h5; wr_byte(8'h77); stb_end();
        check("after_partial_ram", disp_ram, model_ram());
        check("after_partial_ferr", ferr_count, 1);

        // Reset in the middle of the third data byte
        stb_start(); send_byte(8'hC0); waddr = 4'h0;
        wr_byte(8'h01); wr_byte(8'h02);
        send_bits(8'h03, 3);
        rst = 1'b0;
        wait_cyc(2);
        for (int a = 0; a < 16; a++) mram[a] = 8'h00;
        check("midrst_ram", disp_ram, 128'h0);
        check("midrst_outs", {sio_dio_oe, sio_dio_out, disp_on, disp_bright, wr_valid, frame_err}, 8'h0);
        sio_clk = 1'b1; sio_stb = 1'b1; sio_dio_in = 1'b1;
        wait_cyc(4);
        rst = 1'b1;
        fixed_mode = 1'b0;
        wait_cyc(10);
        check("midrst_queue_empty", wr_q.size(), 0);
        cmd_frame(8'h40);
        stb_start(); send_byte(8'hC8); waddr = 4'h8;
        wr_byte(8'hA1); wr_byte(8'hB2);
        stb_end();
        check("postrst_ram", disp_ram, model_ram());
        check("postrst_queue_empty", wr_q.size(), 0);
        check("postrst_ferr", ferr_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tm1638_responder.md
# tm1638_responder

Synthesizable device-side (responder) model of the TM1638 LED&KEY serial protocol. It accepts the STB/CLK/DIO frames issued by our TM1638 board controller, decodes data, address and display-control commands, and maintains the 16-byte display RAM. It returns 4 key-scan bytes on read commands. It is used for on-FPGA loopback of the controller and as the bus-functional target in controller regression benches.

## Interface
- SYNC_STAGES, 2: synchronizer depth on sio_clk, sio_stb and sio_dio_in. Minimum 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset. Asserted when 0.
- sio_clk  in  1  serial clock from the initiator. Idles high.
- sio_stb  in  1  frame strobe, active low.
- sio_dio_in  in  1  DIO pin as seen at the pad.
- sio_dio_out  out  1  DIO drive value.
- sio_dio_oe  out  1  DIO output enable. The top level builds the tristate from sio_dio_out and sio_dio_oe.
- key_scan  in  32  key-scan bytes. Byte i is key_scan[8i+7:8i].
- disp_ram  out  128  display RAM. Address a is disp_ram[8a+7:8a].
- disp_on  out  1  display-enable bit from the last display-control command.
- disp_bright  out  3  brightness from the last display-control command.
- wr_valid  out  1  one-cycle pulse for each RAM write.
- wr_addr  out  4  address of the RAM write.
- wr_data  out  8  data of the RAM write.
- frame_err  out  1  one-cycle pulse when STB rises with a partial byte received.

## Operation
- **Input conditioning:** each input passes through SYNC_STAGES flops. Rising and falling edges of sio_clk and sio_stb are detected on the synchronized signals.
- **Bit reception:** on each sio_clk rising edge while STB is low, the synchronized DIO is shifted in LSB-first, and a 3-bit counter increments. A byte is complete on the 8th rising edge; the counter then wraps to 0.
- **States:**
  - IDLE: STB high. A falling edge of STB goes to CMD.
  - CMD: the first byte of the frame is a command. Decode on bits [7:6]:
    - 01, data command: bit2 = fixed address (1) or auto-increment (0). Bit2 is stored in a persistent mode register. If bit1=1, snapshot key_scan, clear the read-byte counter and go to RDATA. Otherwise go to IGNORE.
    - 11, address command: addr ← bits[3:0], go to WDATA.
    - 10, display control: disp_on ← bit3, disp_bright ← bits[2:0], go to IGNORE.
    - 00: go to IGNORE.
  - WDATA: each complete byte writes RAM[addr] and pulses wr_valid with that addr and data. In auto mode addr then increments, with 4-bit wrap from 15 to 0. In fixed mode addr is unchanged.
  - RDATA: on each sio_clk falling edge, drive the next bit of the current snapshot byte (LSB first) and set sio_dio_oe=1. After 8 bits, advance to the next byte. Bytes beyond the 4th read as 0x00.
  - IGNORE: bytes are counted but discarded.
- **Frame end:** a rising edge of STB from any state leads to IDLE, and sio_dio_oe ← 0. If the bit counter ≠ 0, pulse frame_err and discard the partial byte.
- **Simultaneous events:** if a sio_clk rising edge and a STB rising edge are detected in the same cycle, the bit is taken first. A byte completed that way is committed, and then the frame closes.
- **Key snapshot:** key_scan changes during RDATA do not alter the bytes of the current frame.
- **Reset values (rst=0, takes effect immediately):**
  - All 16 RAM bytes are 0x00.
  - disp_on=0, disp_bright=0, mode=auto-increment, addr=0.
  - sio_dio_oe=0, sio_dio_out=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0.
  - State is IDLE.
  - Reset mid-frame abandons the frame. Bits already received are not written.

## Timing
- **Edge detection:** an edge is detected SYNC_STAGES+1 clk cycles after it appears at the pin.
- **RAM write:** wr_valid and the disp_ram update occur 1 cycle after detection of the 8th rising edge. With SYNC_STAGES=2 that is 4 cycles after the pin edge.
- **Read drive:** sio_dio_out and sio_dio_oe update 1 cycle after detection of the sio_clk falling edge.
- **Display control:** disp_on and disp_bright update 1 cycle after the command byte completes.
- **Pulse outputs:** frame_err and wr_valid are exactly 1 cycle wide. Back-to-back bytes never merge pulses.
- **Minimum SIO timing:** required sio_clk half-period is at least SYNC_STAGES+3 clk cycles. STB high time must be at least SYNC_STAGES+2 cycles.

## Test plan
- **Auto-increment write:** frame 0x40, then frame 0xC0 followed by 0x00..0x0F → disp_ram byte a = a, and 16 wr_valid pulses with addresses 0..15 in order.
- **Fixed address with wrap:**
  - 0x44, then 0xC3, 0xAA, 0x55 → RAM[3]=0x55, with wr_valid twice at addr 3. RAM[2] and RAM[4] are unchanged.
  - Then 0x40, then 0xCE, 0x11, 0x22, 0x33 → RAM[14]=0x11, RAM[15]=0x22, RAM[0]=0x33.
- **Key read:** key_scan=0x80402010, frame 0x42 plus 5 read bytes → DIO returns 0x10, 0x20, 0x40, 0x80, 0x00, LSB-first. Changing key_scan mid-frame has no effect. sio_dio_oe=0 within SYNC_STAGES+2 cycles of STB rising.
- **Display control:** 0x8F → disp_on=1, disp_bright=7. Then 0x80 → disp_on=0, disp_bright=0. No wr_valid occurs in either frame.
- **Partial byte:** 0xC5 followed by 5 bits, then STB rises → single frame_err pulse, no wr_valid, RAM[5] unchanged. The next frame decodes correctly.
- **Reset mid-frame:** rst=0 during the 3rd data byte of a write frame → RAM is all zeros, outputs are at reset values, and the state is IDLE. After rst=1, a full write frame succeeds.
